// File: rtl/vga_plot_if.sv
// Requester-side pixel handshake shared by the two drawing clients of vga_plot_arbiter.
// Each client holds req with stable x/y/colour until it sees its one-cycle ack.
interface vga_plot_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3
);
  logic          req0;
  logic          req1;
  logic [XW-1:0] x0;
  logic [XW-1:0] x1;
  logic [YW-1:0] y0;
  logic [YW-1:0] y1;
  logic [CW-1:0] colour0;
  logic [CW-1:0] colour1;
  logic          ack0;
  logic          ack1;

  modport master (
    output req0, req1, x0, x1, y0, y1, colour0, colour1,
    input  ack0, ack1
  );

  modport slave (
    input  req0, req1, x0, x1, y0, y1, colour0, colour1,
    output ack0, ack1
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Serialises two pixel requesters and a full-frame clear engine onto the VGA
// adapter's single write port; round-robin between requesters, clear locks them out.
module vga_plot_arbiter #(
  parameter            RESOLUTION           = "160x120",
  parameter int        COLOUR_CHANNEL_DEPTH = 1,
  localparam bit       HI_RES               = (RESOLUTION == "320x240"),
  localparam int       W                    = HI_RES ? 320 : 160,
  localparam int       H                    = HI_RES ? 240 : 120,
  localparam int       XW                   = HI_RES ? 9 : 8,
  localparam int       YW                   = HI_RES ? 8 : 7,
  localparam int       CW                   = 3 * COLOUR_CHANNEL_DEPTH
) (
  input  logic          vga_clock,
  input  logic          resetn,
  vga_plot_if.slave     bus,
  input  logic          clear_start,
  input  logic [CW-1:0] clear_colour,
  output logic          clear_busy,
  output logic          clear_done,
  output logic          oob,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic [CW-1:0] out_colour,
  output logic          out_plot
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [XW-1:0] X_LIMIT = XW'(W);
  localparam logic [YW-1:0] Y_LIMIT = YW'(H);
  localparam logic [XW-1:0] X_LAST  = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(H - 1);

  state_t        state;
  logic          ptr;        // 0 favours req0 when both are eligible
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [CW-1:0] fill;

  logic          elig0;
  logic          elig1;
  logic          grant1;
  logic [XW-1:0] sel_x;
  logic [YW-1:0] sel_y;
  logic [CW-1:0] sel_colour;

  // A requester whose ack is currently visible is still holding req; it must
  // not be granted again on this edge.
  always_comb begin
    elig0      = bus.req0 && !bus.ack0;
    elig1      = bus.req1 && !bus.ack1;
    grant1     = (elig0 && elig1) ? ptr : elig1;
    sel_x      = grant1 ? bus.x1      : bus.x0;
    sel_y      = grant1 ? bus.y1      : bus.y0;
    sel_colour = grant1 ? bus.colour1 : bus.colour0;
  end

  // NOTE: every register here uses <= so all state updates see pre-edge values;
  // mixing blocking assignments into a clocked block creates order-dependent races.
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      cx         <= '0;
      cy         <= '0;
      fill       <= '0;
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      oob        <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_colour <= '0;
      out_plot   <= 1'b0;
    end else begin
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      clear_done <= 1'b0;
      oob        <= 1'b0;
      out_plot   <= 1'b0;

      case (state)
        IDLE: begin
          if (clear_start) begin
            fill       <= clear_colour;
            cx         <= '0;
            cy         <= '0;
            clear_busy <= 1'b1;
            state      <= CLEAR;
          end else if (elig0 || elig1) begin
            ptr        <= !grant1;
            out_x      <= sel_x;
            out_y      <= sel_y;
            out_colour <= sel_colour;
            bus.ack0   <= !grant1;
            bus.ack1   <= grant1;
            // Out-of-range requests are still consumed so the client never stalls.
            if (sel_x < X_LIMIT && sel_y < Y_LIMIT) out_plot <= 1'b1;
            else                                    oob      <= 1'b1;
          end
        end

        CLEAR: begin
          out_x      <= cx;
          out_y      <= cy;
          out_colour <= fill;
          out_plot   <= 1'b1;
          if (cx == X_LAST) begin
            cx <= '0;
            if (cy == Y_LAST) begin
              clear_busy <= 1'b0;
              clear_done <= 1'b1;
              state      <= IDLE;
            end else begin
              cy <= cy + 1'b1;
            end
          end else begin
            cx <= cx + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter at 160x120: a pixel-index reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_vga_plot_arbiter;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  logic          vga_clock = 1'b0;
  logic          resetn    = 1'b1;
  logic          clear_start;
  logic [CW-1:0] clear_colour;
  logic          clear_busy;
  logic          clear_done;
  logic          oob;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic [CW-1:0] out_colour;
  logic          out_plot;

  int checks   = 0;
  int failures = 0;

  vga_plot_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

  vga_plot_arbiter #(
    .RESOLUTION           ("160x120"),
    .COLOUR_CHANNEL_DEPTH (1)
  ) dut (
    .vga_clock    (vga_clock),
    .resetn       (resetn),
    .bus          (bus.slave),
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done),
    .oob          (oob),
    .out_x        (out_x),
    .out_y        (out_y),
    .out_colour   (out_colour),
    .out_plot     (out_plot)
  );

  always #20 vga_clock = ~vga_clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      if (failures <= 25)
        $display("FAIL %s actual=%0d required=%0d t=%0t", name, actual, required, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A clear is a walk over pixel indices 0..W*H-1; a grant goes to whichever
  // eligible requester was not served most recently in a tie.
  logic          m_clearing = 1'b0;
  int            m_pix      = 0;
  logic [CW-1:0] m_fill     = '0;
  logic          m_favour1  = 1'b0;
  logic          e_ack0 = 1'b0, e_ack1 = 1'b0, e_oob = 1'b0, e_done = 1'b0;
  logic          e_busy = 1'b0, e_plot = 1'b0;
  logic [XW-1:0] e_x = '0;
  logic [YW-1:0] e_y = '0;
  logic [CW-1:0] e_col = '0;

  logic m_el0, m_el1, m_g1;
  int   m_gx, m_gy;
  assign m_el0 = bus.req0 && !e_ack0;
  assign m_el1 = bus.req1 && !e_ack1;
  assign m_g1  = (m_el0 && m_el1) ? m_favour1 : m_el1;
  assign m_gx  = m_g1 ? int'(bus.x1) : int'(bus.x0);
  assign m_gy  = m_g1 ? int'(bus.y1) : int'(bus.y0);

  always @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      m_clearing <= 1'b0; m_pix <= 0; m_fill <= '0; m_favour1 <= 1'b0;
      e_ack0 <= 1'b0; e_ack1 <= 1'b0; e_oob <= 1'b0; e_done <= 1'b0;
      e_busy <= 1'b0; e_plot <= 1'b0; e_x <= '0; e_y <= '0; e_col <= '0;
    end else begin
      e_ack0 <= 1'b0; e_ack1 <= 1'b0; e_oob <= 1'b0; e_done <= 1'b0; e_plot <= 1'b0;
      if (m_clearing) begin
        e_x    <= XW'(m_pix % W);
        e_y    <= YW'(m_pix / W);
        e_col  <= m_fill;
        e_plot <= 1'b1;
        if (m_pix == W * H - 1) begin
          m_clearing <= 1'b0; e_busy <= 1'b0; e_done <= 1'b1;
        end else begin
          m_pix <= m_pix + 1;
        end
      end else if (clear_start) begin
        m_clearing <= 1'b1; e_busy <= 1'b1; m_pix <= 0; m_fill <= clear_colour;
      end else if (m_el0 || m_el1) begin
        m_favour1 <= !m_g1;
        e_x   <= XW'(m_gx);
        e_y   <= YW'(m_gy);
        e_col <= m_g1 ? bus.colour1 : bus.colour0;
        if (m_g1) e_ack1 <= 1'b1; else e_ack0 <= 1'b1;
        if (m_gx < W && m_gy < H) e_plot <= 1'b1; else e_oob <= 1'b1;
      end
    end
  end

  always @(negedge vga_clock) begin
    if (resetn) begin
      check("cmp_ack0",   bus.ack0,   e_ack0);
      check("cmp_ack1",   bus.ack1,   e_ack1);
      check("cmp_oob",    oob,        e_oob);
      check("cmp_done",   clear_done, e_done);
      check("cmp_busy",   clear_busy, e_busy);
      check("cmp_plot",   out_plot,   e_plot);
      check("cmp_x",      out_x,      e_x);
      check("cmp_y",      out_y,      e_y);
      check("cmp_colour", out_colour, e_col);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic start_clear(input logic [CW-1:0] colour);
    @(negedge vga_clock);
    clear_start  = 1'b1;
    clear_colour = colour;
    @(negedge vga_clock);
    clear_start  = 1'b0;
  endtask

  // Follows a running sweep until clear_done (bounded), optionally pulsing a
  // second clear_start restart_at cycles in.
  task automatic sweep(input int restart_at, output int plots, output int dones,
                       output int fx, output int fy, output int lx, output int ly);
    bit seen = 1'b0;
    plots = 0; dones = 0; fx = -1; fy = -1; lx = -1; ly = -1;
    for (int i = 0; i < W * H + 100 && !seen; i++) begin
      @(negedge vga_clock);
      clear_start = (i == restart_at);
      if (i == restart_at) clear_colour = 3'b001;
      if (out_plot) begin
        if (plots == 0) begin fx = out_x; fy = out_y; end
        plots++;
      end
      if (clear_done) begin
        dones++; lx = out_x; ly = out_y; seen = 1'b1;
      end
    end
    clear_start = 1'b0;
  endtask

  initial begin
    int n0, n1, np, plots, dones, fx, fy, lx, ly;
    bit reached;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.x0 = '0; bus.y0 = '0; bus.colour0 = '0;
    bus.x1 = '0; bus.y1 = '0; bus.colour1 = '0;
    clear_start = 1'b0; clear_colour = '0;

    #5 resetn = 1'b0;
    #1;
    check("reset_plot", out_plot, 0);
    check("reset_ack",  {bus.ack0, bus.ack1}, 0);
    check("reset_busy", clear_busy, 0);
    check("reset_xyc",  {out_x, out_y, out_colour}, 0);
    repeat (2) @(negedge vga_clock);
    #5 resetn = 1'b1;

    // Single request, no double ack while req0 lingers
    @(negedge vga_clock);
    bus.req0 = 1'b1; bus.x0 = 8'd5; bus.y0 = 7'd7; bus.colour0 = 3'b101;
    @(negedge vga_clock);
    check("single_ack0", bus.ack0, 1);
    check("single_plot", out_plot, 1);
    check("single_xyc",  {out_x, out_y, out_colour}, {8'd5, 7'd7, 3'd5});
    @(negedge vga_clock);
    check("single_no_reack", bus.ack0, 0);
    check("single_plot_off", out_plot, 0);
    bus.req0 = 1'b0;

    // Out of range then the far corner
    @(negedge vga_clock);
    bus.req1 = 1'b1; bus.x1 = 8'd160; bus.y1 = 7'd0; bus.colour1 = 3'b011;
    @(negedge vga_clock);
    check("oob_ack1", bus.ack1, 1);
    check("oob_flag", oob, 1);
    check("oob_plot", out_plot, 0);
    bus.req1 = 1'b0;
    @(negedge vga_clock);
    bus.req1 = 1'b1; bus.x1 = 8'd159; bus.y1 = 7'd119; bus.colour1 = 3'b110;
    @(negedge vga_clock);
    check("corner_ack1", bus.ack1, 1);
    check("corner_plot", out_plot, 1);
    check("corner_oob",  oob, 0);
    check("corner_xy",   {out_x, out_y}, {8'd159, 7'd119});
    bus.req1 = 1'b0;

    // Contention: pointer favours req0 after two req1 grants
    @(negedge vga_clock);
    bus.req0 = 1'b1; bus.x0 = 8'd10; bus.y0 = 7'd11; bus.colour0 = 3'b001;
    bus.req1 = 1'b1; bus.x1 = 8'd20; bus.y1 = 7'd21; bus.colour1 = 3'b010;
    n0 = 0; n1 = 0; np = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge vga_clock);
      if (i == 0) check("cont_first_ack0", bus.ack0, 1);
      if (i == 1) check("cont_second_x",   out_x, 20);
      n0 += int'(bus.ack0); n1 += int'(bus.ack1); np += int'(out_plot);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    check("cont_n_ack0", n0, 4);
    check("cont_n_ack1", n1, 4);
    check("cont_n_plot", np, 8);

    // Clear beats a simultaneous request
    @(negedge vga_clock);
    clear_start = 1'b1; clear_colour = 3'b010;
    bus.req0 = 1'b1; bus.x0 = 8'd3; bus.y0 = 7'd4; bus.colour0 = 3'b111;
    @(negedge vga_clock);
    clear_start = 1'b0;
    check("clr_busy",    clear_busy, 1);
    check("clr_no_ack0", bus.ack0, 0);
    sweep(-1, plots, dones, fx, fy, lx, ly);
    check("clr_plots", plots, W * H);
    check("clr_dones", dones, 1);
    check("clr_first", {fx[7:0], fy[7:0]}, 16'h0000);
    check("clr_last",  {lx[7:0], ly[7:0]}, {8'd159, 8'd119});
    check("clr_busy_end", clear_busy, 0);
    @(negedge vga_clock);
    check("clr_then_ack0", bus.ack0, 1);
    check("clr_then_x",    out_x, 3);
    bus.req0 = 1'b0;

    // clear_start mid-sweep is ignored
    start_clear(3'b110);
    sweep(100, plots, dones, fx, fy, lx, ly);
    check("restart_plots", plots, W * H);
    check("restart_dones", dones, 1);
    np = 0; n0 = 0;
    repeat (20) begin
      @(negedge vga_clock);
      np += int'(out_plot); n0 += int'(clear_done);
    end
    check("restart_quiet_plot", np, 0);
    check("restart_quiet_done", n0, 0);

    // Reset in the middle of a sweep
    start_clear(3'b011);
    reached = 1'b0;
    for (int i = 0; i < 9000 && !reached; i++) begin
      @(negedge vga_clock);
      if (out_plot && out_y == 7'd50) reached = 1'b1;
    end
    check("rst_reached_row50", reached, 1);
    #5 resetn = 1'b0;
    #1;
    check("rst_plot", out_plot, 0);
    check("rst_busy", clear_busy, 0);
    check("rst_done", clear_done, 0);
    check("rst_xyc",  {out_x, out_y, out_colour}, 0);
    @(negedge vga_clock);
    #5 resetn = 1'b1;
    np = 0; n0 = 0;
    repeat (5) begin
      @(negedge vga_clock);
      np += int'(out_plot); n0 += int'(clear_done);
    end
    check("rst_idle_plot", np, 0);
    check("rst_idle_done", n0, 0);
    start_clear(3'b100);
    sweep(-1, plots, dones, fx, fy, lx, ly);
    check("rst_new_first", {fx[7:0], fy[7:0]}, 16'h0000);
    check("rst_new_plots", plots, W * H);
    check("rst_new_dones", dones, 1);

    repeat (3) @(negedge vga_clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
